// File: rtl/int_fp_mac_pkg.sv
// Shared constants and types for the INT/FP16 multiply datapath.
package int_fp_mac_pkg;
    localparam logic        MODE_FP        = 1'b1;
    localparam logic        MODE_INT       = 1'b0;
    localparam int          FIFO_DEPTH_DEF = 4;
    localparam logic [15:0] FP_QNAN        = 16'h7E00;

    typedef struct packed {
        logic        mode;
        logic [15:0] res;
    } res_t;
endpackage

// File: rtl/int_fp_mul.sv
// Combinational 16-bit multiplier: low 16 bits of a*b in INT mode, IEEE half
// product (round-to-nearest-even, subnormals flushed to zero) in FP mode.
module int_fp_mul
    import int_fp_mac_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        mode,
    output logic [15:0] result
);
    logic              sgn;
    logic [4:0]        ea, eb;
    logic [9:0]        fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0]       prod;
    logic signed [7:0] exp_s;
    logic [9:0]        mant;
    logic              grd, stk;
    logic [10:0]       mant_r;
    logic [15:0]       int_lo;

    always_comb begin
        sgn    = a[15] ^ b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        fa     = a[9:0];
        fb     = b[9:0];
        a_nan  = (ea == 5'h1F) && (fa != 10'd0);
        b_nan  = (eb == 5'h1F) && (fb != 10'd0);
        a_inf  = (ea == 5'h1F) && (fa == 10'd0);
        b_inf  = (eb == 5'h1F) && (fb == 10'd0);
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        int_lo = a * b;

        prod  = 22'({1'b1, fa}) * 22'({1'b1, fb});
        exp_s = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
        if (prod[21]) begin
            mant  = prod[20:11];
            grd   = prod[10];
            stk   = |prod[9:0];
            exp_s = exp_s + 8'sd1;
        end else begin
            mant  = prod[19:10];
            grd   = prod[9];
            stk   = |prod[8:0];
        end
        // Round-up carry out of the mantissa bumps the exponent; mantissa wraps to 0.
        mant_r = {1'b0, mant} + {10'd0, grd & (stk | mant[0])};
        if (mant_r[10]) exp_s = exp_s + 8'sd1;

        if (mode == MODE_INT)
            result = int_lo;
        else if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            result = FP_QNAN;
        else if (a_inf || b_inf)
            result = {sgn, 15'h7C00};
        else if (a_zero || b_zero)
            result = {sgn, 15'h0000};
        else if (exp_s >= 8'sd31)
            result = {sgn, 15'h7C00};
        else if (exp_s <= 8'sd0)
            result = {sgn, 15'h0000};
        else
            result = {sgn, exp_s[4:0], mant_r[9:0]};
    end
endmodule

// File: rtl/int_fp_mul_stream.sv
// Streaming wrapper: S1 operand register, int_fp_mul, S2 result register, result
// FIFO. Input credit covers every in-flight beat so S1/S2 never stall.
module int_fp_mul_stream
    import int_fp_mac_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_mode,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [1:0]       vld_pipe_q, vld_pipe_d;  // [0] = S1, [1] = S2
    logic [15:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s1_mode_q, s1_mode_d;
    res_t             s2_q, s2_d;
    res_t             fifo_mem_q [FIFO_DEPTH];
    res_t             fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             rdy_en_q, rdy_en_d;
    logic [15:0]      mul_res;
    logic [CW:0]      inflight;
    logic             accept, push, pop;

    int_fp_mul u_mul (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .mode   (s1_mode_q),
        .result (mul_res)
    );

    always_comb begin
        inflight = {1'b0, fifo_cnt_q} + {{CW{1'b0}}, vld_pipe_q[0]}
                 + {{CW{1'b0}}, vld_pipe_q[1]};
        // rdy_en_q keeps in_ready low while reset is held, high from the first cycle after.
        in_ready   = rdy_en_q && (inflight < (CW + 1)'(FIFO_DEPTH));
        out_valid  = (fifo_cnt_q != '0);
        out_result = out_valid ? fifo_mem_q[rd_ptr_q].res  : 16'h0000;
        out_mode   = out_valid ? fifo_mem_q[rd_ptr_q].mode : 1'b0;
        busy       = (|vld_pipe_q) || out_valid;
        op_count   = op_count_q;

        accept = in_valid && in_ready;
        push   = vld_pipe_q[1];
        pop    = out_valid && out_ready;

        vld_pipe_d = {vld_pipe_q[0], accept};
        s1_a_d     = accept ? in_a    : s1_a_q;
        s1_b_d     = accept ? in_b    : s1_b_q;
        s1_mode_d  = accept ? in_mode : s1_mode_q;
        s2_d       = vld_pipe_q[0] ? res_t'{mode: s1_mode_q, res: mul_res} : s2_q;

        fifo_mem_d = fifo_mem_q;
        if (push) fifo_mem_d[wr_ptr_q] = s2_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        op_count_d = op_count_q + CNT_W'(accept);
        rdy_en_d   = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= 1'b0;
            s2_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            op_count_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_q       <= s2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            op_count_q <= op_count_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    // Storage needs no reset: entries are only visible when fifo_cnt_q covers them.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end
endmodule

// File: tb/tb_int_fp_mul_stream.sv
// Directed bench for int_fp_mul_stream: vector table with scoreboard plus
// latency, burst, backpressure, full push/pop and mid-stream reset sequences.
module tb_int_fp_mul_stream;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int NV    = 21;

    logic          clk = 1'b0, reset = 1'b1;
    logic          in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic [15:0]   in_a = '0, in_b = '0;
    logic          in_ready, out_valid, out_mode, busy;
    logic [15:0]   out_result;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    int_fp_mul_stream #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_mode(out_mode),
        .busy(busy), .op_count(op_count)
    );

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t        vt [NV];
    int          tests = 0, fails = 0;
    logic [16:0] sb_q [$];
    logic        acc = 1'b0, prev_hold = 1'b0;
    logic [16:0] prev_out = '0, cur_exp = '0;
    int unsigned acc_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int idx);
        in_mode = vt[idx].mode;
        in_a    = vt[idx].a;
        in_b    = vt[idx].b;
        cur_exp = {vt[idx].mode, vt[idx].exp};
    endtask

    // Evaluate the handshakes the coming posedge will see, then advance to the next negedge.
    task automatic cyc();
        acc = in_valid && in_ready;
        if (acc) begin
            sb_q.push_back(cur_exp);
            acc_total++;
        end
        if (prev_hold) chk("hold_stable", {15'd0, out_mode, out_result}, {15'd0, prev_out});
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h with nothing outstanding",
                         {out_mode, out_result});
            end else begin
                chk("result_order", {15'd0, out_mode, out_result}, {15'd0, sb_q.pop_front()});
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = {out_mode, out_result};
        @(negedge clk);
    endtask

    task automatic run_stream(input int first, input int n, input bit rnd, output bit held);
        int i;
        int guard;
        i = 0;
        guard = 0;
        held = 1'b1;
        while ((i < n || sb_q.size() != 0 || busy) && guard < 400) begin
            in_valid = (i < n);
            if (i < n) drive(first + i);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i < n && !in_ready) held = 1'b0;
            cyc();
            if (acc) i++;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (guard >= 400) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: %0d of %0d accepted, %0d outstanding", i, n, sb_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit held;
        int lat, nacc;
        logic stale;

        vt[0]  = '{1'b1, 16'h3C00, 16'h3C00, 16'h3C00};
        vt[1]  = '{1'b1, 16'h4000, 16'h3E00, 16'h4200};
        vt[2]  = '{1'b1, 16'h4000, 16'h4000, 16'h4400};
        vt[3]  = '{1'b1, 16'hC000, 16'h3C00, 16'hC000};
        vt[4]  = '{1'b1, 16'h3800, 16'h3800, 16'h3400};
        vt[5]  = '{1'b1, 16'h3E00, 16'h3E00, 16'h4080};
        vt[6]  = '{1'b1, 16'h3FFF, 16'h3FFF, 16'h43FE};
        vt[7]  = '{1'b1, 16'h3E01, 16'h3C01, 16'h3E03};
        vt[8]  = '{1'b1, 16'h3C01, 16'h3C01, 16'h3C02};
        vt[9]  = '{1'b1, 16'h7C00, 16'h3C00, 16'h7C00};
        vt[10] = '{1'b1, 16'h7C00, 16'h0000, 16'h7E00};
        vt[11] = '{1'b1, 16'h7BFF, 16'h4000, 16'h7C00};
        vt[12] = '{1'b1, 16'h0000, 16'hC000, 16'h8000};
        vt[13] = '{1'b1, 16'h7E00, 16'h3C00, 16'h7E00};
        vt[14] = '{1'b1, 16'h0400, 16'h0400, 16'h0000};
        vt[15] = '{1'b1, 16'h3C00, 16'hC400, 16'hC400};
        vt[16] = '{1'b0, 16'h0003, 16'h0005, 16'h000F};
        vt[17] = '{1'b0, 16'h0100, 16'h0100, 16'h0000};
        vt[18] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001};
        vt[19] = '{1'b0, 16'h1234, 16'h0010, 16'h2340};
        vt[20] = '{1'b0, 16'hFFFE, 16'h0002, 16'hFFFC};

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",   32'(in_ready),   0);
        chk("rst_out_valid",  32'(out_valid),  0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_mode",   32'(out_mode),   0);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_op_count",   32'(op_count),   0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 1);

        // Single FP16 beat: out_valid three cycles after the accepting cycle.
        drive(0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("single_accept", 32'(acc), 1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk("single_latency", lat, 3);
        chk("single_result", 32'(out_result), 32'h3C00);
        cyc();
        out_ready = 1'b0;
        chk("single_op_count", 32'(op_count), 1);

        // Back-to-back burst of eight FP16 beats with a free-running consumer.
        run_stream(0, 8, 1'b0, held);
        chk("burst_ready_held", 32'(held), 1);
        chk("burst_op_count", 32'(op_count), 32'(acc_total % 16));
        chk("burst_idle", 32'(busy), 0);

        // Backpressure: only FIFO_DEPTH beats fit, a single pop frees one credit.
        out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            drive(16 + nacc);
            cyc();
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        chk("bp_accepts", nacc, 4);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("bp_ready_after_pop", 32'(in_ready), 1);
        chk("bp_valid_after_pop", 32'(out_valid), 1);
        chk("bp_next_head", 32'(out_result), 32'h0000);
        run_stream(0, 0, 1'b0, held);

        // FIFO at 3 with S2 valid: simultaneous push and pop keeps the count.
        out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 8 && nacc < 4; c++) begin
            in_valid = 1'b1;
            drive(8 + nacc);
            cyc();
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        chk("pp_accepts", nacc, 4);
        cyc();
        chk("pp_pre_fifo_cnt", 32'(dut.fifo_cnt_q), 3);
        chk("pp_pre_s2_valid", 32'(dut.vld_pipe_q[1]), 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("pp_fifo_cnt", 32'(dut.fifo_cnt_q), 3);
        run_stream(0, 0, 1'b0, held);
        chk("pp_none_lost", sb_q.size(), 0);

        // Reset with two beats in flight.
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            drive(12 + c);
            cyc();
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_in_ready",   32'(in_ready),   0);
        chk("mid_rst_out_valid",  32'(out_valid),  0);
        chk("mid_rst_out_result", 32'(out_result), 0);
        chk("mid_rst_out_mode",   32'(out_mode),   0);
        chk("mid_rst_busy",       32'(busy),       0);
        chk("mid_rst_op_count",   32'(op_count),   0);
        sb_q.delete();
        acc_total = 0;
        prev_hold = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid || busy) stale = 1'b1;
            cyc();
        end
        out_ready = 1'b0;
        chk("no_stale_after_reset", 32'(stale), 0);

        // Full table with a random consumer; 21 beats also wrap the 4-bit op_count.
        run_stream(0, NV, 1'b1, held);
        chk("replay_outstanding", sb_q.size(), 0);
        chk("op_count_wrap", 32'(op_count), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
